// File: rtl/shift_unit_pipe_pkg.sv
// Shared definitions for the pipelined shifter.
//   shift_op_e        : operation encodings (also consumed by the ALU control decoder)
//   levels_per_stage  : mux levels packed into one pipeline stage
//   stage_lvl_lo/hi   : first/last mux level handled by a given stage
package shift_unit_pipe_pkg;

  typedef enum logic [1:0] {
    SH_SLL  = 2'd0,
    SH_SRL  = 2'd1,
    SH_SRA  = 2'd2,
    SH_ROTR = 2'd3
  } shift_op_e;

  function automatic int levels_per_stage(input int shamt_w, input int stages);
    return (shamt_w + stages - 1) / stages;
  endfunction

  // Trailing stages may own no levels at all (e.g. 5 levels over 4 stages
  // gives 2,2,1,0); such a stage reports lo = hi + 1 and is a plain register.
  function automatic int stage_lvl_lo(input int shamt_w, input int stages, input int idx);
    int lo;
    lo = idx * levels_per_stage(shamt_w, stages);
    return (lo > shamt_w) ? shamt_w : lo;
  endfunction

  function automatic int stage_lvl_hi(input int shamt_w, input int stages, input int idx);
    int hi;
    hi = (idx + 1) * levels_per_stage(shamt_w, stages);
    return ((hi > shamt_w) ? shamt_w : hi) - 1;
  endfunction

endpackage

// File: rtl/shift_unit_pipe_stage.sv
// One pipeline stage of the barrel shifter.
// Applies mux levels LVL_LO..LVL_HI (shift by 2^k when shamt[k]=1) to the
// upstream operand and registers the result together with op, full shamt,
// tag and a valid bit.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           clears the valid bit at the next edge
//   load_ready      this stage may load this cycle (computed by the top)
//   up_*            upstream valid/operand/op/shamt/tag
//   valid/data/op/shamt/tag  registered stage contents
module shift_stage
  import shift_unit_pipe_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int LVL_LO  = 0,
  parameter int LVL_HI  = 4,
  parameter int TAG_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               load_ready,
  input  logic               up_valid,
  input  logic [WIDTH-1:0]   up_data,
  input  logic [1:0]         up_op,
  input  logic [SHAMT_W-1:0] up_shamt,
  input  logic [TAG_W-1:0]   up_tag,
  output logic               valid,
  output logic [WIDTH-1:0]   data,
  output logic [1:0]         op,
  output logic [SHAMT_W-1:0] shamt,
  output logic [TAG_W-1:0]   tag
);

  localparam int NLVL = (LVL_HI >= LVL_LO) ? (LVL_HI - LVL_LO + 1) : 0;

  // One level: fixed shift by s in the requested mode. SRA replicates the
  // current MSB, which stays equal to the original sign bit at every level.
  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                input logic [1:0] mode,
                                                input int s);
    logic signed [WIDTH-1:0] sd;
    logic [WIDTH-1:0] r;
    sd = d;
    case (mode)
      SH_SLL:  r = d << s;
      SH_SRL:  r = d >> s;
      SH_SRA:  r = sd >>> s;
      default: r = (d >> s) | (d << (WIDTH - s));
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0]   lvl_data [0:NLVL];
  logic               valid_reg;
  logic [WIDTH-1:0]   data_reg;
  logic [1:0]         op_reg;
  logic [SHAMT_W-1:0] shamt_reg;
  logic [TAG_W-1:0]   tag_reg;

  assign lvl_data[0] = up_data;

  generate
    for (genvar gi = 0; gi < NLVL; gi++) begin : g_lvl
      localparam int K = LVL_LO + gi;
      assign lvl_data[gi+1] = up_shamt[K] ? shift_by(lvl_data[gi], up_op, 1 << K)
                                          : lvl_data[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      op_reg    <= '0;
      shamt_reg <= '0;
      tag_reg   <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (load_ready) begin
      valid_reg <= up_valid;
      // Payload only moves with a real op, so an emptied stage keeps its
      // last contents instead of capturing idle upstream values.
      if (up_valid) begin
        data_reg  <= lvl_data[NLVL];
        op_reg    <= up_op;
        shamt_reg <= up_shamt;
        tag_reg   <= up_tag;
      end
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;
  assign op    = op_reg;
  assign shamt = shamt_reg;
  assign tag   = tag_reg;

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROTR) with valid/ready on both sides,
// a tag passthrough and a flush for branch squash.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               squash every in-flight op; blocks input this cycle
//   in_valid/in_ready   input handshake
//   in_op, in_data, in_shamt, in_tag   operation, operand, amount, tag
//   out_valid/out_ready output handshake
//   out_data, out_tag   result and its tag, straight from the last stage
module shift_unit_pipe
  import shift_unit_pipe_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STAGES  = 2,
  parameter int TAG_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  // Index i carries the inputs of stage i; index STAGES is the last stage's output.
  logic               s_valid [0:STAGES];
  logic [WIDTH-1:0]   s_data  [0:STAGES];
  logic [1:0]         s_op    [0:STAGES];
  logic [SHAMT_W-1:0] s_shamt [0:STAGES];
  logic [TAG_W-1:0]   s_tag   [0:STAGES];

  logic [STAGES-1:0]  valid_vec;
  logic [STAGES-1:0]  stage_ready;
  logic               unused_tail;

  assign s_valid[0] = in_valid;
  assign s_data[0]  = in_data;
  assign s_op[0]    = in_op;
  assign s_shamt[0] = in_shamt;
  assign s_tag[0]   = in_tag;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO = stage_lvl_lo(SHAMT_W, STAGES, gi);
      localparam int HI = stage_lvl_hi(SHAMT_W, STAGES, gi);

      assign valid_vec[gi] = s_valid[gi+1];

      // Unrolled form of ready_i = !valid_i | ready_{i+1}, ready_STAGES = out_ready:
      // a stage may load unless it and every stage after it are full and the
      // consumer is stalling. Avoids a combinational chain through the array.
      assign stage_ready[gi] = out_ready | ~(&valid_vec[STAGES-1:gi]);

      shift_stage #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W),
        .LVL_LO  (LO),
        .LVL_HI  (HI),
        .TAG_W   (TAG_W)
      ) u_stage (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .load_ready (stage_ready[gi]),
        .up_valid   (s_valid[gi]),
        .up_data    (s_data[gi]),
        .up_op      (s_op[gi]),
        .up_shamt   (s_shamt[gi]),
        .up_tag     (s_tag[gi]),
        .valid      (s_valid[gi+1]),
        .data       (s_data[gi+1]),
        .op         (s_op[gi+1]),
        .shamt      (s_shamt[gi+1]),
        .tag        (s_tag[gi+1])
      );
    end
  endgenerate

  assign in_ready  = stage_ready[0] & ~flush;
  assign out_valid = s_valid[STAGES];
  assign out_data  = s_data[STAGES];
  assign out_tag   = s_tag[STAGES];

  // The final stage's op and shamt have no consumer.
  assign unused_tail = ^{s_op[STAGES], s_shamt[STAGES]};

endmodule

// File: tb/tb_shift_unit_pipe.sv
module tb_shift_unit_pipe;

  localparam int W  = 32;
  localparam int SW = 5;
  localparam int TW = 5;
  localparam int SWEEP_CYC = 300;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]    in_op;
  logic [W-1:0]  in_data, out_data;
  logic [SW-1:0] in_shamt;
  logic [TW-1:0] in_tag, out_tag;

  // Sweep instances STAGES=1..5 share one random stimulus stream.
  logic          sw_valid;
  logic [1:0]    sw_op;
  logic [W-1:0]  sw_data;
  logic [SW-1:0] sw_shamt;
  logic [TW-1:0] sw_tag;
  logic          sw_ir [1:5];
  logic          sw_ov [1:5];
  logic [W-1:0]  sw_od [1:5];
  logic [TW-1:0] sw_ot [1:5];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_unit_pipe #(.WIDTH(W), .SHAMT_W(SW), .STAGES(2), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_data(in_data), .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  for (genvar g = 1; g <= 5; g++) begin : g_sw
    shift_unit_pipe #(.WIDTH(W), .SHAMT_W(SW), .STAGES(g), .TAG_W(TW)) u_sw (
      .clk(clk), .rst(rst), .flush(1'b0),
      .in_valid(sw_valid), .in_ready(sw_ir[g]), .in_op(sw_op),
      .in_data(sw_data), .in_shamt(sw_shamt), .in_tag(sw_tag),
      .out_valid(sw_ov[g]), .out_ready(1'b1),
      .out_data(sw_od[g]), .out_tag(sw_ot[g])
    );
  end

  // Reference: shifts on a double-width word, then take the relevant half.
  function automatic logic [W-1:0] ref_shift(input logic [1:0] op,
                                             input logic [W-1:0] d,
                                             input logic [SW-1:0] sh);
    logic [2*W-1:0] t;
    case (op)
      2'd0:    t = {{W{1'b0}}, d} << sh;
      2'd1:    t = {{W{1'b0}}, d} >> sh;
      2'd2:    t = {{W{d[W-1]}}, d} >> sh;
      default: t = {d, d} >> sh;
    endcase
    return t[W-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [W-1:0]  data;
    logic [SW-1:0] shamt;
    logic [TW-1:0] tag;
    logic [W-1:0]  exp;
  } vec_t;

  typedef struct {
    logic [W-1:0]  d;
    logic [TW-1:0] t;
  } res_t;

  vec_t vecs [10];
  res_t exp_q [$];
  logic          hv [0:SWEEP_CYC-1];
  logic [W-1:0]  hd [0:SWEEP_CYC-1];
  logic [TW-1:0] ht [0:SWEEP_CYC-1];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int sent, got;
    bit saw_low, held;
    logic [W-1:0]  held_d;
    logic [TW-1:0] held_t;
    res_t r;

    vecs[0] = '{2'd0, 32'h0000_0003,  5'd2,  5'd7,  32'h0000_000C};
    vecs[1] = '{2'd2, 32'h8000_0000,  5'd31, 5'd1,  32'hFFFF_FFFF};
    vecs[2] = '{2'd1, 32'h8000_0000,  5'd31, 5'd2,  32'h0000_0001};
    vecs[3] = '{2'd3, 32'h0000_0001,  5'd1,  5'd3,  32'h8000_0000};
    vecs[4] = '{2'd0, 32'hDEAD_BEEF,  5'd0,  5'd4,  32'hDEAD_BEEF};
    vecs[5] = '{2'd2, 32'h1234_5678,  5'd0,  5'd5,  32'h1234_5678};
    vecs[6] = '{2'd3, 32'hA5A5_0F0F,  5'd4,  5'd6,  32'hFA5A_50F0};
    vecs[7] = '{2'd2, 32'hF000_0000,  5'd4,  5'd8,  32'hFF00_0000};
    vecs[8] = '{2'd1, 32'hF000_0000,  5'd4,  5'd9,  32'h0F00_0000};
    vecs[9] = '{2'd0, 32'hFFFF_FFFF,  5'd31, 5'd31, 32'h8000_0000};

    rst = 1; flush = 0; in_valid = 0; in_op = 0; in_data = 0; in_shamt = 0; in_tag = 0;
    out_ready = 1;
    sw_valid = 0; sw_op = 0; sw_data = 0; sw_shamt = 0; sw_tag = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_tag", out_tag, 0);
    chk("reset in_ready", in_ready, 1);

    // Directed vectors, one op at a time, latency exactly 2.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1; in_op = vecs[i].op; in_data = vecs[i].data;
      in_shamt = vecs[i].shamt; in_tag = vecs[i].tag;
      #1 chk($sformatf("vec%0d in_ready", i), in_ready, 1);
      @(negedge clk);
      in_valid = 0;
      chk($sformatf("vec%0d early valid", i), out_valid, 0);
      @(negedge clk);
      chk($sformatf("vec%0d valid", i), out_valid, 1);
      chk($sformatf("vec%0d data", i), out_data, vecs[i].exp);
      chk($sformatf("vec%0d tag", i), out_tag, vecs[i].tag);
    end

    // Stream of 8 ops with a consumer stall on cycles 3-5.
    sent = 0; got = 0; saw_low = 0; held = 0; held_d = 0; held_t = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 5);
      in_valid = (sent < 8);
      if (sent < 8) begin
        in_op = 2'($urandom_range(0, 3)); in_data = $urandom;
        in_shamt = 5'($urandom_range(0, 31)); in_tag = 5'(sent + 16);
      end
      #1;
      if (held) begin
        chk("stall data stable", out_data, held_d);
        chk("stall tag stable", out_tag, held_t);
      end
      if (!in_ready) saw_low = 1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("stream extra result", 1, 0);
        else begin
          r = exp_q.pop_front();
          chk($sformatf("stream%0d data", got), out_data, r.d);
          chk($sformatf("stream%0d tag", got), out_tag, r.t);
        end
        got++;
      end
      held = out_valid && !out_ready; held_d = out_data; held_t = out_tag;
      if (in_valid && in_ready) begin
        exp_q.push_back('{ref_shift(in_op, in_data, in_shamt), in_tag});
        sent++;
      end
    end
    in_valid = 0; out_ready = 1;
    chk("stream results", got, 8);
    chk("stream in_ready fell", saw_low, 1);
    chk("stream queue empty", exp_q.size(), 0);

    // Flush with two ops in flight and in_valid high.
    @(negedge clk);
    in_valid = 1; in_op = 2'd0; in_data = 32'h1; in_shamt = 5'd1; in_tag = 5'd10;
    @(negedge clk);
    in_tag = 5'd11;
    @(negedge clk);
    flush = 1; in_tag = 5'd12;
    #1 chk("flush in_ready", in_ready, 0);
    @(negedge clk);
    flush = 0; in_valid = 0;
    chk("flush out_valid", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("flush drained %0d", i), out_valid, 0);
    end
    @(negedge clk);
    in_valid = 1; in_op = 2'd1; in_data = 32'hF0F0_0000; in_shamt = 5'd8; in_tag = 5'd13;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    chk("post-flush valid", out_valid, 1);
    chk("post-flush data", out_data, 32'h00F0_F000);
    chk("post-flush tag", out_tag, 5'd13);

    // Reset with the pipeline full and stalled.
    @(negedge clk);
    out_ready = 0; in_valid = 1; in_op = 2'd3; in_data = 32'h55; in_shamt = 5'd3; in_tag = 5'd20;
    @(negedge clk);
    in_tag = 5'd21;
    @(negedge clk);
    in_valid = 0;
    #1 chk("full before rst", out_valid, 1);
    chk("full in_ready", in_ready, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_tag", out_tag, 0);
    chk("rst in_ready", in_ready, 1);
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst drained %0d", i), out_valid, 0);
    end

    // Random sweep across STAGES=1..5.
    for (int k = 0; k < SWEEP_CYC; k++) begin
      @(negedge clk);
      for (int s = 1; s <= 5; s++) begin
        chk($sformatf("sweep S%0d in_ready", s), sw_ir[s], 1);
        if (k >= s && hv[k-s]) begin
          chk($sformatf("sweep S%0d c%0d valid", s, k), sw_ov[s], 1);
          chk($sformatf("sweep S%0d c%0d data", s, k), sw_od[s], hd[k-s]);
          chk($sformatf("sweep S%0d c%0d tag", s, k), sw_ot[s], ht[k-s]);
        end else begin
          chk($sformatf("sweep S%0d c%0d idle", s, k), sw_ov[s], 0);
        end
      end
      sw_valid = ($urandom_range(0, 3) != 0);
      sw_op = 2'($urandom_range(0, 3));
      sw_data = $urandom;
      sw_shamt = 5'($urandom_range(0, 31));
      sw_tag = 5'(k);
      hv[k] = sw_valid;
      hd[k] = ref_shift(sw_op, sw_data, sw_shamt);
      ht[k] = sw_tag;
    end
    sw_valid = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
